// File: rtl/lcd_update_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_update_scheduler_if                                                  |
// | Byte stream between the LCD update scheduler and the I2C byte engine.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface lcd_update_scheduler_if;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_first;
  logic       tx_last;
  logic       tx_ready;
  logic       tx_nack;

  modport master (
    output tx_valid, tx_byte, tx_first, tx_last,
    input  tx_ready, tx_nack
  );

  modport slave (
    input  tx_valid, tx_byte, tx_first, tx_last,
    output tx_ready, tx_nack
  );
endinterface
`default_nettype wire

// File: rtl/lcd_update_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_update_scheduler                                                     |
// | Fixed-priority arbiter and 5-byte frame streamer for the LCD I2C engine. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lcd_update_scheduler #(
  parameter int         REFRESH_TICKS = 1000,
  parameter logic [6:0] LCD_ADDR      = 7'h27,
  parameter int         MAX_RETRY     = 3
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  input  wire logic              sensor_enable,
  input  wire logic [23:0]       lcd_data,
  input  wire logic [23:0]       lcd_message_data,
  input  wire logic              alert_req,
  input  wire logic [7:0]        alert_code,
  lcd_update_scheduler_if.master tx,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err,
  output logic [7:0]             frame_count
);

  localparam int c_TW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
  localparam int c_RW = $clog2(MAX_RETRY + 1);
  localparam logic [c_TW-1:0] c_TLAST     = c_TW'(REFRESH_TICKS - 1);
  localparam logic [c_RW-1:0] c_MAX_RETRY = c_RW'(MAX_RETRY);
  localparam logic [1:0] c_SRC_SENS = 2'd0;
  localparam logic [1:0] c_SRC_MSG  = 2'd1;
  localparam logic [1:0] c_SRC_ALRT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_ABORT = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [c_TW-1:0] r_timer;
  logic            r_sens_p, r_msg_p, r_alrt_p;
  logic [7:0]      r_alert_code;
  logic [23:0]     r_last_msg;
  logic [1:0]      r_src;
  logic [7:0]      r_cmd;
  logic [23:0]     r_payload;
  logic [2:0]      r_idx;
  logic [c_RW-1:0] r_retry;
  logic            r_frame_done, r_err;
  logic [7:0]      r_frame_count;

  logic            w_any, w_grant, w_wrap, w_hs, w_last_hs, w_nack_hs;
  logic            w_retry_ok, w_abort_retry, w_abort_drop, w_keep_snap;
  logic [1:0]      w_src_sel;
  logic [c_RW-1:0] w_retry_inc;

  assign w_any         = r_sens_p | r_msg_p | r_alrt_p;
  assign w_grant       = (r_state == S_IDLE) && w_any;
  assign w_src_sel     = r_alrt_p ? c_SRC_ALRT : (r_msg_p ? c_SRC_MSG : c_SRC_SENS);
  assign w_wrap        = sensor_enable && (r_timer == c_TLAST);
  assign w_hs          = (r_state == S_SEND) && tx.tx_ready;
  assign w_last_hs     = w_hs && (r_idx == 3'd4) && !tx.tx_nack;
  assign w_nack_hs     = w_hs && tx.tx_nack;
  assign w_retry_inc   = c_RW'(r_retry + 1'b1);
  assign w_retry_ok    = (w_retry_inc < c_MAX_RETRY);
  assign w_abort_retry = (r_state == S_ABORT) && w_retry_ok;
  assign w_abort_drop  = (r_state == S_ABORT) && !w_retry_ok;
  // A retried request re-uses its snapshot so the retry is byte-identical.
  assign w_keep_snap   = (w_src_sel == r_src) && (r_retry != '0);

  assign busy        = (r_state != S_IDLE) || w_any;
  assign frame_done  = r_frame_done;
  assign err         = r_err;
  assign frame_count = r_frame_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    tx.tx_valid = 1'b0;
    tx.tx_byte  = 8'h00;
    tx.tx_first = 1'b0;
    tx.tx_last  = 1'b0;
    case (r_state)
      S_IDLE: if (w_any) w_state_nxt = S_SEND;
      S_SEND: begin
        tx.tx_valid = 1'b1;
        tx.tx_first = (r_idx == 3'd0);
        tx.tx_last  = (r_idx == 3'd4);
        case (r_idx)
          3'd0:    tx.tx_byte = {LCD_ADDR, 1'b0};
          3'd1:    tx.tx_byte = r_cmd;
          3'd2:    tx.tx_byte = r_payload[23:16];
          3'd3:    tx.tx_byte = r_payload[15:8];
          default: tx.tx_byte = r_payload[7:0];
        endcase
        if (w_nack_hs)      w_state_nxt = S_ABORT;
        else if (w_last_hs) w_state_nxt = S_IDLE;
      end
      S_ABORT: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request flags: a new event wins over a same-cycle grant clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer      <= '0;
      r_sens_p     <= 1'b0;
      r_msg_p      <= 1'b0;
      r_alrt_p     <= 1'b0;
      r_alert_code <= 8'h00;
      r_last_msg   <= 24'h000000;
    end else begin
      if (!sensor_enable)      r_timer <= '0;
      else if (w_wrap)         r_timer <= '0;
      else                     r_timer <= c_TW'(r_timer + 1'b1);

      if (!sensor_enable) begin
        r_sens_p <= 1'b0;
      end else begin
        if (w_grant && w_src_sel == c_SRC_SENS)      r_sens_p <= 1'b0;
        if (w_abort_retry && r_src == c_SRC_SENS)    r_sens_p <= 1'b1;
        if (w_wrap)                                  r_sens_p <= 1'b1;
      end

      if (w_grant && w_src_sel == c_SRC_MSG) begin
        r_msg_p    <= 1'b0;
        r_last_msg <= lcd_message_data;
      end else if (lcd_message_data != r_last_msg) begin
        r_msg_p <= 1'b1;
      end
      if (w_abort_retry && r_src == c_SRC_MSG) r_msg_p <= 1'b1;

      if (w_grant && w_src_sel == c_SRC_ALRT) begin
        r_alrt_p <= 1'b0;
      end else if (alert_req && !r_alrt_p) begin
        r_alrt_p     <= 1'b1;
        r_alert_code <= alert_code;
      end
      if (w_abort_retry && r_src == c_SRC_ALRT) r_alrt_p <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src         <= c_SRC_SENS;
      r_cmd         <= 8'h00;
      r_payload     <= 24'h000000;
      r_idx         <= 3'd0;
      r_retry       <= '0;
      r_frame_done  <= 1'b0;
      r_err         <= 1'b0;
      r_frame_count <= 8'h00;
    end else begin
      r_frame_done <= w_last_hs;
      if (w_grant) begin
        r_src <= w_src_sel;
        r_idx <= 3'd0;
        if (!w_keep_snap) begin
          case (w_src_sel)
            c_SRC_ALRT: begin
              r_cmd     <= 8'hCD;
              r_payload <= {r_alert_code, 8'h21, 8'h21};
            end
            c_SRC_MSG: begin
              r_cmd     <= 8'hC0;
              r_payload <= lcd_message_data;
            end
            default: begin
              r_cmd     <= 8'h80;
              r_payload <= lcd_data;
            end
          endcase
        end
      end else if (w_hs) begin
        r_idx <= 3'(r_idx + 3'd1);
      end

      if (w_last_hs) begin
        r_frame_count <= r_frame_count + 8'd1;
        r_retry       <= '0;
      end else if (r_state == S_ABORT) begin
        r_retry <= w_retry_ok ? w_retry_inc : '0;
      end
      if (w_abort_drop) r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_update_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lcd_update_scheduler                                                  |
// | Directed-vector bench for the LCD update scheduler.                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_lcd_update_scheduler;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        sensor_enable;
  logic [23:0] lcd_data;
  logic [23:0] lcd_message_data;
  logic        alert_req;
  logic [7:0]  alert_code;
  logic        busy, frame_done, err;
  logic [7:0]  frame_count;
  logic [7:0]  cnt0;
  logic [39:0] exp_frame;
  int          err_cnt = 0;
  int          chk_cnt = 0;
  logic [9:0]  q[$];

  lcd_update_scheduler_if bus ();

  lcd_update_scheduler #(
    .REFRESH_TICKS (8),
    .LCD_ADDR      (7'h27),
    .MAX_RETRY     (3)
  ) u_dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .sensor_enable    (sensor_enable),
    .lcd_data         (lcd_data),
    .lcd_message_data (lcd_message_data),
    .alert_req        (alert_req),
    .alert_code       (alert_code),
    .tx               (bus),
    .busy             (busy),
    .frame_done       (frame_done),
    .err              (err),
    .frame_count      (frame_count)
  );

  always #5 clk = ~clk;

  // Record every accepted byte as {first, last, byte}.
  always @(negedge clk)
    if (reset_n && bus.tx_valid && bus.tx_ready)
      q.push_back({bus.tx_first, bus.tx_last, bus.tx_byte});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_first(input string tag);
    for (int i = 0; i < 100 && !(bus.tx_valid && bus.tx_first); i++) tick();
    check_eq(tag, {31'd0, bus.tx_valid && bus.tx_first}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && busy; i++) tick();
    check_eq(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic expect_frame(input string tag, input logic [39:0] bytes);
    logic [9:0] e;
    for (int i = 0; i < 200 && q.size() < 5; i++) tick();
    if (q.size() < 5) begin
      check_eq({tag, "_timeout"}, q.size(), 32'd5);
      return;
    end
    for (int k = 0; k < 5; k++) begin
      e = q.pop_front();
      check_eq(tag, {22'd0, e}, {22'd0, (k == 0), (k == 4), bytes[39-8*k -: 8]});
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    sensor_enable    = 1'b0;
    lcd_data         = 24'h000000;
    lcd_message_data = 24'h49444C;
    alert_req        = 1'b0;
    alert_code       = 8'h00;
    bus.tx_ready     = 1'b1;
    bus.tx_nack      = 1'b0;
    repeat (2) tick();
    check_eq("rst_outs", {22'd0, bus.tx_valid, bus.tx_byte, bus.tx_first, bus.tx_last}, 32'd0);
    check_eq("rst_status", {21'd0, busy, frame_done, err, frame_count}, 32'd0);

    // Message frame straight after reset, back-to-back bytes.
    reset_n = 1'b1;
    tick();
    check_eq("t1_grant", {30'd0, busy, bus.tx_valid}, 32'b10);
    tick();
    exp_frame = 40'h4EC049444C;
    for (int k = 0; k < 5; k++) begin
      check_eq("t1_byte", {22'd0, bus.tx_valid, bus.tx_first, bus.tx_last, bus.tx_byte},
               {22'd0, 1'b1, (k == 0), (k == 4), exp_frame[39-8*k -: 8]});
      tick();
    end
    check_eq("t1_done", {21'd0, frame_done, busy, frame_count}, {21'd0, 1'b1, 1'b0, 8'd1});
    tick();
    check_eq("t1_done_pulse", {31'd0, frame_done}, 32'd0);

    // Periodic sensor frames, REFRESH_TICKS=8.
    q.delete();
    lcd_data      = 24'h7F3210;
    sensor_enable = 1'b1;
    repeat (8) tick();
    check_eq("t2_grant", {30'd0, busy, bus.tx_valid}, 32'b10);
    tick();
    check_eq("t2_start1", {22'd0, bus.tx_valid, bus.tx_first, bus.tx_byte}, {22'd0, 2'b11, 8'h4E});
    repeat (8) tick();
    check_eq("t2_start2", {22'd0, bus.tx_valid, bus.tx_first, bus.tx_byte}, {22'd0, 2'b11, 8'h4E});
    sensor_enable = 1'b0;
    expect_frame("t2_frame1", 40'h4E807F3210);
    expect_frame("t2_frame2", 40'h4E807F3210);
    wait_idle("t2_idle");
    check_eq("t2_count", {24'd0, frame_count}, 32'd3);

    // Alert, message change and timer wrap in the same cycle.
    q.delete();
    sensor_enable = 1'b1;
    repeat (7) tick();
    alert_req        = 1'b1;
    alert_code       = 8'h45;
    lcd_message_data = 24'h574154;
    tick();
    alert_req = 1'b0;
    expect_frame("t3_alert", 40'h4ECD452121);
    expect_frame("t3_msg", 40'h4EC0574154);
    expect_frame("t3_sens", 40'h4E807F3210);
    sensor_enable = 1'b0;
    wait_idle("t3_idle");
    q.delete();

    // Stalled byte engine: every byte held for one extra cycle.
    bus.tx_ready     = 1'b0;
    lcd_message_data = 24'h444F4E;
    for (int i = 0; i < 50 && !bus.tx_valid; i++) tick();
    exp_frame = 40'h4EC0444F4E;
    for (int k = 0; k < 5; k++) begin
      check_eq("t4_present", {22'd0, bus.tx_valid, bus.tx_first, bus.tx_last, bus.tx_byte},
               {22'd0, 1'b1, (k == 0), (k == 4), exp_frame[39-8*k -: 8]});
      tick();
      check_eq("t4_hold", {22'd0, bus.tx_valid, bus.tx_first, bus.tx_last, bus.tx_byte},
               {22'd0, 1'b1, (k == 0), (k == 4), exp_frame[39-8*k -: 8]});
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
    end
    check_eq("t4_done", {31'd0, frame_done}, 32'd1);
    bus.tx_ready = 1'b1;
    check_eq("t4_count", q.size(), 32'd5);
    expect_frame("t4_frame", exp_frame);

    // NACK on byte 2 three times: two retries, then drop with err.
    q.delete();
    cnt0             = frame_count;
    lcd_message_data = 24'h49444C;
    for (int a = 0; a < 3; a++) begin
      wait_first("t5_start");
      check_eq("t5_err_clear", {31'd0, err}, 32'd0);
      tick();
      tick();
      check_eq("t5_byte2", {23'd0, bus.tx_valid, bus.tx_byte}, {23'd0, 1'b1, 8'h49});
      bus.tx_nack = 1'b1;
      tick();
      bus.tx_nack = 1'b0;
      check_eq("t5_abort", {30'd0, bus.tx_valid, busy}, 32'b01);
    end
    tick();
    check_eq("t5_dropped", {22'd0, err, busy, frame_count}, {22'd0, 1'b1, 1'b0, cnt0});
    q.delete();
    lcd_message_data = 24'h574154;
    expect_frame("t5_after", 40'h4EC0574154);
    wait_idle("t5_idle");
    check_eq("t5_sticky", {23'd0, err, frame_count}, {23'd0, 1'b1, 8'(cnt0 + 8'd1)});

    // Asynchronous reset during byte 3, then the message is resent.
    q.delete();
    lcd_message_data = 24'h444F4E;
    wait_first("t6_start");
    repeat (3) tick();
    check_eq("t6_byte3", {23'd0, bus.tx_valid, bus.tx_byte}, {23'd0, 1'b1, 8'h4F});
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t6_async_outs", {22'd0, bus.tx_valid, bus.tx_byte, bus.tx_first, bus.tx_last}, 32'd0);
    check_eq("t6_async_status", {21'd0, busy, frame_done, err, frame_count}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    q.delete();
    tick();
    check_eq("t6_grant", {30'd0, busy, bus.tx_valid}, 32'b10);
    tick();
    check_eq("t6_start", {22'd0, bus.tx_valid, bus.tx_first, bus.tx_byte}, {22'd0, 2'b11, 8'h4E});
    expect_frame("t6_frame", 40'h4EC0444F4E);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/lcd_update_scheduler.md
# lcd_update_scheduler

Scheduler that owns the shared I2C byte engine driving the garden-monitor LCD and decides which frame goes out next. It has three requesters: a periodic sensor-readout refresh, a status-message change, and an alert. It arbitrates between them by fixed priority, snapshots the winning payload, and streams a 5-byte frame over a valid/ready handshake. It also handles NACK retries and error reporting.

## Interface
Parameters:
- REFRESH_TICKS, 1000: clock cycles between sensor-frame requests.
- LCD_ADDR, 7'h27: 7-bit I2C address of the LCD backpack.
- MAX_RETRY, 3: number of consecutive NACK-aborted attempts before a request is dropped.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sensor_enable  input  1  enables the refresh timer.
- lcd_data  input  24  scaled sensor frame {soil, temp, rain}.
- lcd_message_data  input  24  3-character ASCII status ("WAT", "DON", "IDL").
- alert_req  input  1  single-cycle alert request pulse.
- alert_code  input  8  alert character, sampled with alert_req.
- tx_ready  input  1  byte engine can accept a byte.
- tx_nack  input  1  NACK for the byte being handshaken; valid only in a handshake cycle.
- tx_valid  output  1  tx_byte is valid.
- tx_byte  output  8  byte to transmit.
- tx_first  output  1  current byte opens the frame (engine issues START).
- tx_last  output  1  current byte closes the frame (engine issues STOP).
- busy  output  1  a frame is in flight.
- frame_done  output  1  one-cycle pulse when a frame completes successfully.
- err  output  1  sticky; set when a request is dropped after MAX_RETRY attempts.
- frame_count  output  8  count of successful frames, wraps modulo 256.

## Operation
- Pending flags (registered):
  - sens_p: set when the refresh timer wraps.
  - msg_p: set whenever lcd_message_data differs from last_msg. last_msg resets to 24'h000000.
  - alrt_p: set by alert_req, which also latches alert_code. An alert_req arriving while alrt_p is already set is ignored and the first code is kept.
- Refresh timer:
  - Counts 0..REFRESH_TICKS-1 while sensor_enable=1 and sets sens_p on wrap.
  - While sensor_enable=0 the timer is held at 0 and sens_p is cleared. A sensor frame already in flight still completes.
- States: IDLE, SEND, ABORT.
- IDLE:
  - If any flag is pending, grant in priority order: alert, then message, then sensor.
  - Snapshot the 3 payload bytes, clear the winner's flag, move to SEND with byte index 0.
  - On a message grant, last_msg is loaded with the snapshot.
- Frame bytes:
  - Byte 0 is {LCD_ADDR,1'b0}.
  - Byte 1 is the command: 8'h80 for sensor, 8'hC0 for message, 8'hCD for alert.
  - Bytes 2-4 are the payload MSB-first. The alert payload is {code, 8'h21, 8'h21}.
- SEND:
  - The byte index advances on each tx_valid && tx_ready.
  - tx_first is high only at index 0; tx_last is high only at index 4.
  - tx_byte, tx_first and tx_last hold stable while tx_valid && !tx_ready.
  - Handshake on index 4 with tx_nack=0: go to IDLE, pulse frame_done, increment frame_count, clear the retry count.
  - Any handshake with tx_nack=1: go to ABORT.
- ABORT (1 cycle), tx_valid=0:
  - Increment the retry count.
  - If the count is below MAX_RETRY, re-set the winner's flag and keep the snapshot so the retry sends identical bytes.
  - Otherwise drop the request, set err, and clear the retry count.
  - Go to IDLE. A retried request competes by priority again.
- A payload change during SEND does not alter the in-flight frame. A message change re-raises msg_p after the frame completes.

## Timing
- Reset values:
  - Outputs: tx_valid=0, tx_byte=0, tx_first=0, tx_last=0, busy=0, frame_done=0, err=0, frame_count=0.
  - Internal: all flags, timer, retry count and last_msg are 0.
  - Reset asserted mid-frame drops tx_valid immediately (asynchronously).
- Grant latency:
  - Flag set at cycle N, state IDLE at N+1 (grant), tx_valid=1 with byte 0 at N+2.
  - A flag set in the same cycle as the arbitration decision is seen one cycle later.
- Throughput: with tx_ready held at 1, the 5 bytes are presented on 5 consecutive cycles.
- Frame completion and inter-frame gap:
  - Last handshake at T: frame_done=1 and busy=0 at T+1.
  - Next tx_valid no earlier than T+2.
- busy is high from the grant cycle through the last handshake cycle, including ABORT.
- Simultaneous events:
  - alert_req and a timer wrap in the same cycle set both flags; the alert is granted first.
  - frame_count wraps 255 -> 0 with no flag.

## Test plan
- After reset, lcd_message_data=24'h49444C, tx_ready=1: bytes 4E,C0,49,44,4C on 5 consecutive cycles with first/last on bytes 0/4, then frame_done, frame_count=1.
- REFRESH_TICKS=8, sensor_enable=1, lcd_data=24'h7F3210, message unchanged: sensor frame 4E,80,7F,32,10 begins 2 cycles after the wrap, repeats every 8 cycles.
- alert_req (code 8'h45) in the same cycle as a timer wrap and a message change: order is alert (4E,CD,45,21,21), then message, then sensor.
- tx_ready toggling 1/0 during a frame: tx_byte, tx_first and tx_last hold while stalled; the frame content is unchanged and no byte is skipped or duplicated.
- tx_nack=1 on byte 2, three times in a row (MAX_RETRY=3): two identical retries, then err=1 and the request dropped; frame_count unchanged; a later frame still succeeds with err remaining 1.
- reset_n pulsed low during byte 3: tx_valid falls asynchronously; after release all outputs are at reset values and the next message frame is resent.
